fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the hazard unit's PCWrite/IF_IDWrite stall controls and the branch/jump redirects (ID-resolved branch/JAL, EX-resolved JALR).
- Drives instruction memory and feeds decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset: synchronous, active-high
- PCWrite  input  1  from hazard unit; 0 holds PC
- IF_IDWrite  input  1  from hazard unit; 0 holds IF/ID register
- ID_Redirect  input  1  branch taken / JAL in ID
- ID_RedirectTarget  input  32  target for ID_Redirect
- EX_Redirect  input  1  JALR in EX
- EX_RedirectTarget  input  32  target for EX_Redirect
- imem_addr  output  32  instruction address (= PC, combinational)
- imem_rdata  input  32  instruction word, combinational read of imem_addr
- IF_ID_PC  output  32  PC of instruction in ID
- IF_ID_PC4  output  32  PC+4 of instruction in ID
- IF_ID_Instr  output  32  instruction in ID
- IF_ID_Valid  output  1  1 = real instruction, 0 = bubble
- ID_EXFlushReq  output  1  registered; asks ID/EX to bubble (EX redirect kills the ID instruction)

Behaviour:
- Reset, synchronous: PC=RESET_PC; IF_ID_PC=0; IF_ID_PC4=0; IF_ID_Instr=NOP_INSTR; IF_ID_Valid=0; ID_EXFlushReq=0. Asserting rst mid-stall or mid-redirect overrides everything.
- First instruction is valid in ID one cycle after rst deasserts.
- Redirect qualification:
  - ID_Redirect is honoured only when PCWrite=1, because a stalled branch in ID is not yet resolved.
  - EX_Redirect is honoured unconditionally.
- Next-PC priority, highest first:
  1. EX_Redirect → EX_RedirectTarget
  2. qualified ID_Redirect → ID_RedirectTarget
  3. PCWrite=0 → hold PC
  4. otherwise PC+4
- All targets have bits [1:0] forced to 0. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- IF/ID update on each edge, first match wins:
  1. Any honoured redirect → flush: Instr=NOP_INSTR, Valid=0, PC and PC4 = 0. This flush overrides IF_IDWrite=0.
  2. IF_IDWrite=0 → hold all IF/ID fields.
  3. Otherwise load: PC←PC, PC4←PC+4, Instr←imem_rdata, Valid←1.
- ID_EXFlushReq is set to 1 for exactly one cycle after an honoured EX_Redirect, else 0.
- Simultaneous EX_Redirect and ID_Redirect: EX wins, because the ID instruction is younger and is being killed.
- PCWrite=1 with IF_IDWrite=0: legal. PC advances and IF/ID holds. The instruction in IF is lost and this is the caller's responsibility; the hazard unit never produces this combination.
- Redirect penalty:
  - ID redirect: 1 bubble.
  - EX redirect: 2 bubbles (IF/ID flush plus ID_EXFlushReq).

Optional Feature:
- Macro FETCH_STAGE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on every edge with PCWrite=0 and no honoured redirect.
  - perf_flush_cnt increments on every honoured redirect.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and do not wrap.
- Undefined: ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Shared package `rv32i_pkg`:
  - RV32I opcode constants: LUI 7'b0110111, AUIPC 7'b0010111, JAL 7'b1101111, JALR 7'b1100111, BRANCH 7'b1100011.
  - NOP_INSTR.
  - RESET_PC default.
- One sub-module, `if_id_reg`: the IF/ID pipeline register with write-enable and flush inputs, kept separate so it can be reused for ID/EX.
- Next-PC mux and PC register stay in `fetch_stage`.

Test Plan:
- Reset then free-run with imem returning addr-derived words: imem_addr sequence 0,4,8,…; IF_ID_Valid=0 until cycle 1 after reset, then 1; IF_ID_PC4 = IF_ID_PC+4.
- PCWrite=0, IF_IDWrite=0 for 2 cycles at PC=0x10: PC stays 0x10, IF/ID holds PC=0xC; resumes at 0x14 after release.
- ID_Redirect=1, target 0x100, at PC=0x20: next imem_addr=0x100; IF/ID becomes NOP, Valid=0; ID_EXFlushReq stays 0.
- ID_Redirect=1 while PCWrite=0: ignored, PC held. EX_Redirect with target 0x203 during the same stall: PC=0x200, IF/ID flushed, ID_EXFlushReq=1 for one cycle.
- EX_Redirect (0x400) and ID_Redirect (0x500) in the same cycle: PC=0x400. Also PC=0xFFFF_FFFC free-run: next PC=0x0.
- With FETCH_STAGE_PERF_CNT_EN: 3 stall cycles plus 2 redirects gives perf_stall_cnt=3 and perf_flush_cnt=2. rst mid-count clears both to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, bubble encoding, reset PC and the IF/ID record.
// The fetch_stage perf counters are enabled with FETCH_STAGE_PERF_CNT_EN.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Instruction fetch is word aligned; redirect targets drop their low two bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding one if_id_t record, with write-enable and flush.
// Flush beats write-enable; reset and flush both load the bubble record.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              flush,
  input  rv32i_pkg::if_id_t entry_in,
  output rv32i_pkg::if_id_t entry_out
);
  import rv32i_pkg::*;

  if_id_t entry_q;
  if_id_t entry_d;
  if_id_t bubble;

  always_comb begin
    bubble       = '0;
    bubble.instr = NOP_INSTR;
  end

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = bubble;
    end else if (wr_en) begin
      entry_d = entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= bubble;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, next-PC priority mux and the IF/ID register.
// Define FETCH_STAGE_PERF_CNT_EN to add saturating stall/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        ID_Redirect,
  input  logic [31:0] ID_RedirectTarget,
  input  logic        EX_Redirect,
  input  logic [31:0] EX_RedirectTarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        ID_EXFlushReq
`ifdef FETCH_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  import rv32i_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic        id_redirect_ok;
  logic        redirect;
  logic        flush_req_q;
  logic        flush_req_d;
  if_id_t      fetch_entry;
  if_id_t      id_entry;

  // A branch in ID under stall has not resolved yet, so it only counts when PC may move.
  always_comb begin
    pc_plus4       = pc_q + 32'd4;
    id_redirect_ok = ID_Redirect & PCWrite;
    redirect       = EX_Redirect | id_redirect_ok;
    flush_req_d    = EX_Redirect;

    pc_d = pc_plus4;
    if (EX_Redirect) begin
      pc_d = align_word(EX_RedirectTarget);
    end else if (id_redirect_ok) begin
      pc_d = align_word(ID_RedirectTarget);
    end else if (!PCWrite) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      flush_req_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      flush_req_q <= flush_req_d;
    end
  end

  always_comb begin
    fetch_entry.pc    = pc_q;
    fetch_entry.pc4   = pc_plus4;
    fetch_entry.instr = imem_rdata;
    fetch_entry.valid = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (IF_IDWrite),
    .flush     (redirect),
    .entry_in  (fetch_entry),
    .entry_out (id_entry)
  );

  assign imem_addr     = pc_q;
  assign IF_ID_PC      = id_entry.pc;
  assign IF_ID_PC4     = id_entry.pc4;
  assign IF_ID_Instr   = id_entry.instr;
  assign IF_ID_Valid   = id_entry.valid;
  assign ID_EXFlushReq = flush_req_q;

`ifdef FETCH_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCWrite && !redirect && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect && flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, perf sequence, then random run
// against a behavioural model. Honours FETCH_STAGE_PERF_CNT_EN when defined.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        ID_Redirect;
  logic [31:0] ID_RedirectTarget;
  logic        EX_Redirect;
  logic [31:0] EX_RedirectTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic        ID_EXFlushReq;
`ifdef FETCH_STAGE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .PCWrite           (PCWrite),
    .IF_IDWrite        (IF_IDWrite),
    .ID_Redirect       (ID_Redirect),
    .ID_RedirectTarget (ID_RedirectTarget),
    .EX_Redirect       (EX_Redirect),
    .EX_RedirectTarget (EX_RedirectTarget),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_PC4         (IF_ID_PC4),
    .IF_ID_Instr       (IF_ID_Instr),
    .IF_ID_Valid       (IF_ID_Valid),
    .ID_EXFlushReq     (ID_EXFlushReq)
`ifdef FETCH_STAGE_PERF_CNT_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-derived instruction words so a wrong fetch address is visible in IF_ID_Instr.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb imem_rdata = imem_word(imem_addr);

  // Behavioural model state
  logic [31:0] m_pc, m_if_pc, m_if_pc4, m_if_instr;
  logic        m_if_valid, m_fr;
  logic [31:0] m_stall, m_flush;

  task automatic model_update(input logic r, input logic pw, input logic iw, input logic idr,
                              input logic [31:0] idt, input logic exr, input logic [31:0] ext);
    logic        take_id;
    logic        redir;
    logic [31:0] fetched;
    if (r) begin
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_pc4 = 32'h0; m_if_instr = NOP;
      m_if_valid = 1'b0; m_fr = 1'b0; m_stall = 32'h0; m_flush = 32'h0;
      return;
    end
    take_id = idr && pw;
    redir   = exr || take_id;
    fetched = imem_word(m_pc);
    if (!pw && !redir && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (redir && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    m_fr = exr;
    if (redir) begin
      m_if_pc = 32'h0; m_if_pc4 = 32'h0; m_if_instr = NOP; m_if_valid = 1'b0;
    end else if (iw) begin
      m_if_pc = m_pc; m_if_pc4 = m_pc + 32'd4; m_if_instr = fetched; m_if_valid = 1'b1;
    end
    if (exr)       m_pc = {ext[31:2], 2'b00};
    else if (take_id) m_pc = {idt[31:2], 2'b00};
    else if (pw)   m_pc = m_pc + 32'd4;
  endtask

  task automatic step(input logic r, input logic pw, input logic iw, input logic idr,
                      input logic [31:0] idt, input logic exr, input logic [31:0] ext);
    rst = r; PCWrite = pw; IF_IDWrite = iw;
    ID_Redirect = idr; ID_RedirectTarget = idt;
    EX_Redirect = exr; EX_RedirectTarget = ext;
    @(posedge clk);
    model_update(r, pw, iw, idr, idt, exr, ext);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " imem_addr"}, imem_addr, m_pc);
    chk({tag, " IF_ID_PC"}, IF_ID_PC, m_if_pc);
    chk({tag, " IF_ID_PC4"}, IF_ID_PC4, m_if_pc4);
    chk({tag, " IF_ID_Instr"}, IF_ID_Instr, m_if_instr);
    chk({tag, " IF_ID_Valid"}, {31'b0, IF_ID_Valid}, {31'b0, m_if_valid});
    chk({tag, " ID_EXFlushReq"}, {31'b0, ID_EXFlushReq}, {31'b0, m_fr});
`ifdef FETCH_STAGE_PERF_CNT_EN
    chk({tag, " perf_stall_cnt"}, perf_stall_cnt, m_stall);
    chk({tag, " perf_flush_cnt"}, perf_flush_cnt, m_flush);
`endif
  endtask

  typedef struct {
    logic        rst, pw, iw, idr;
    logic [31:0] idt;
    logic        exr;
    logic [31:0] ext;
    logic [31:0] e_pc, e_ifpc;
    logic        e_valid, e_fr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic pw, input logic iw, input logic idr,
                              input logic [31:0] idt, input logic exr, input logic [31:0] ext,
                              input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic e_valid, input logic e_fr);
    vec_t v;
    v.rst = r; v.pw = pw; v.iw = iw; v.idr = idr; v.idt = idt; v.exr = exr; v.ext = ext;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_valid = e_valid; v.e_fr = e_fr;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_instr, e_pc4;
    string       tag;
    //              rst pw iw idr idt           exr ext           pc            ifpc          v  fr
    tbl[0]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 32'h40,       1, 32'h50,       32'h0,        32'h0,        0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        1, 0);
    tbl[3]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        1, 0);
    tbl[4]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        1, 0);
    tbl[5]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC,        1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC,        1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC,        1, 0);
    tbl[8]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h14,       32'h10,       1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h18,       32'h14,       1, 0);
    tbl[10] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h1C,       32'h18,       1, 0);
    tbl[11] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h20,       32'h1C,       1, 0);
    tbl[12] = mk(0, 1, 1, 1, 32'h100,      0, 32'h0,        32'h100,      32'h0,        0, 0);
    tbl[13] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h104,      32'h100,      1, 0);
    tbl[14] = mk(0, 0, 0, 1, 32'h300,      0, 32'h0,        32'h104,      32'h100,      1, 0);
    tbl[15] = mk(0, 0, 0, 1, 32'h300,      1, 32'h203,      32'h200,      32'h0,        0, 1);
    tbl[16] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h204,      32'h200,      1, 0);
    tbl[17] = mk(0, 1, 1, 1, 32'h500,      1, 32'h400,      32'h400,      32'h0,        0, 1);
    tbl[18] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h404,      32'h400,      1, 0);
    tbl[19] = mk(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 32'h0,       32'hFFFF_FFFC, 32'h0,       0, 0);
    tbl[20] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'hFFFF_FFFC, 1, 0);
    tbl[21] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        1, 0);
    tbl[22] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h0,        1, 0);
    tbl[23] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        1, 0);
    tbl[24] = mk(1, 0, 0, 0, 32'h0,        1, 32'h700,      32'h0,        32'h0,        0, 0);
    tbl[25] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        1, 0);
    tbl[26] = mk(0, 1, 0, 1, 32'h82,       0, 32'h0,        32'h80,       32'h0,        0, 0);
    tbl[27] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h84,       32'h80,       1, 0);

    rst = 1'b1; PCWrite = 1'b1; IF_IDWrite = 1'b1; ID_Redirect = 1'b0; ID_RedirectTarget = '0;
    EX_Redirect = 1'b0; EX_RedirectTarget = '0;
    @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].pw, tbl[i].iw, tbl[i].idr, tbl[i].idt, tbl[i].exr, tbl[i].ext);
      e_instr = tbl[i].e_valid ? imem_word(tbl[i].e_ifpc) : NOP;
      e_pc4   = tbl[i].e_valid ? tbl[i].e_ifpc + 32'd4 : 32'h0;
      tag = $sformatf("vec%0d", i);
      chk({tag, " imem_addr"}, imem_addr, tbl[i].e_pc);
      chk({tag, " IF_ID_PC"}, IF_ID_PC, tbl[i].e_ifpc);
      chk({tag, " IF_ID_PC4"}, IF_ID_PC4, e_pc4);
      chk({tag, " IF_ID_Instr"}, IF_ID_Instr, e_instr);
      chk({tag, " IF_ID_Valid"}, {31'b0, IF_ID_Valid}, {31'b0, tbl[i].e_valid});
      chk({tag, " ID_EXFlushReq"}, {31'b0, ID_EXFlushReq}, {31'b0, tbl[i].e_fr});
      $display("vec %0d: addr=%08h if_pc=%08h valid=%0b flushreq=%0b", i, imem_addr, IF_ID_PC,
               IF_ID_Valid, ID_EXFlushReq);
    end

`ifdef FETCH_STAGE_PERF_CNT_EN
    step(1, 1, 1, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h120, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h240);
    chk("perf stall after 3 stalls", perf_stall_cnt, 32'd3);
    chk("perf flush after 2 redirects", perf_flush_cnt, 32'd2);
    $display("perf: stall=%0d flush=%0d", perf_stall_cnt, perf_flush_cnt);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h10, 0, 32'h0);
    chk("perf stall after rst", perf_stall_cnt, 32'd0);
    chk("perf flush after rst", perf_flush_cnt, 32'd0);
    $display("perf after rst: stall=%0d flush=%0d", perf_stall_cnt, perf_flush_cnt);
`endif

    step(1, 1, 1, 0, 32'h0, 0, 32'h0);
    chk_model("rand reset");
    for (int i = 0; i < 400; i++) begin
      logic        r, pw, iw, idr, exr;
      logic [31:0] idt, ext;
      r   = ($urandom_range(0, 49) == 0);
      pw  = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : pw;
      idr = ($urandom_range(0, 9) == 0);
      exr = ($urandom_range(0, 11) == 0);
      idt = $urandom;
      ext = $urandom;
      step(r, pw, iw, idr, idt, exr, ext);
      chk_model($sformatf("rand%0d", i));
      $display("rand %0d: rst=%0b pw=%0b iw=%0b idr=%0b exr=%0b addr=%08h if_pc=%08h valid=%0b",
               i, r, pw, iw, idr, exr, imem_addr, IF_ID_PC, IF_ID_Valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
